// File: rtl/pwm_duty_stage_if.sv
// ============================================================================
// Module  : pwm_duty_stage_if
// Brief   : Duty request / PWM result bundle between a duty source and the
//           PWM duty stage.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface pwm_duty_stage_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] duty;
    logic             pwm_out;
    logic             period_end;
    logic [WIDTH-1:0] duty_active;

    modport master (
        output enable,
        output duty,
        input  pwm_out,
        input  period_end,
        input  duty_active
    );

    modport slave (
        input  enable,
        input  duty,
        output pwm_out,
        output period_end,
        output duty_active
    );
endinterface

`default_nettype wire

// File: rtl/pwm_duty_stage.sv
// ============================================================================
// Module  : pwm_duty_stage
// Brief   : PWM generator whose duty is latched once per period, giving a
//           glitch-free waveform from a continuously changing duty source.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module pwm_duty_stage #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1,
    parameter bit INVERT   = 1'b0
) (
    input  wire logic         clock,
    input  wire logic         reset,
    pwm_duty_stage_if.slave   bus
);

    localparam int               c_PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0]  c_PRE_MAX    = c_PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] c_LAST_PHASE = WIDTH'(2**WIDTH - 2);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state,       w_state_nxt;
    logic [c_PW-1:0]  r_pre_cnt,     w_pre_cnt_nxt;
    logic [WIDTH-1:0] r_phase,       w_phase_nxt;
    logic [WIDTH-1:0] r_duty_active, w_duty_active_nxt;
    logic             w_tick;
    logic             w_wrap;

    assign w_tick = (r_state == S_RUN) && (r_pre_cnt == c_PRE_MAX);
    assign w_wrap = w_tick && (r_phase == c_LAST_PHASE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pre_cnt     <= '0;
            r_phase       <= '0;
            r_duty_active <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_pre_cnt     <= w_pre_cnt_nxt;
            r_phase       <= w_phase_nxt;
            r_duty_active <= w_duty_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_pre_cnt_nxt     = '0;
        w_phase_nxt       = '0;
        w_duty_active_nxt = r_duty_active;
        case (r_state)
            S_IDLE: begin
                if (bus.enable) begin
                    w_state_nxt       = S_RUN;
                    w_duty_active_nxt = bus.duty;
                end
            end
            S_RUN: begin
                // Dropping enable wins over a simultaneous wrap: no duty reload.
                if (!bus.enable) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_pre_cnt_nxt = w_tick ? '0 : r_pre_cnt + 1'b1;
                    w_phase_nxt   = r_phase;
                    if (w_tick) begin
                        w_phase_nxt = w_wrap ? '0 : r_phase + 1'b1;
                    end
                    if (w_wrap) begin
                        w_duty_active_nxt = bus.duty;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Phase tops out one below 2**WIDTH-1, so full-scale duty never drops low.
    assign bus.pwm_out     = ((r_state == S_RUN) && (r_phase < r_duty_active)) ^ INVERT;
    assign bus.period_end  = w_wrap;
    assign bus.duty_active = r_duty_active;

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_stage.sv
// ============================================================================
// Module  : tb_pwm_duty_stage
// Brief   : Directed bench for pwm_duty_stage (prescale 1, prescale 4, inverted).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pwm_duty_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pwm_duty_stage_if #(.WIDTH(4)) ifa ();
    pwm_duty_stage_if #(.WIDTH(4)) ifb ();
    pwm_duty_stage_if #(.WIDTH(4)) ifc ();

    pwm_duty_stage #(.WIDTH(4), .PRESCALE(1), .INVERT(1'b0)) u_dut_a (
        .clock (clk), .reset (rst), .bus (ifa.slave));
    pwm_duty_stage #(.WIDTH(4), .PRESCALE(4), .INVERT(1'b0)) u_dut_b (
        .clock (clk), .reset (rst), .bus (ifb.slave));
    pwm_duty_stage #(.WIDTH(4), .PRESCALE(1), .INVERT(1'b1)) u_dut_c (
        .clock (clk), .reset (rst), .bus (ifc.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [3:0] tri_val(input int i);
        int m;
        m = i % 30;
        return (m < 16) ? m[3:0] : 4'(30 - m);
    endfunction

    initial begin
        logic [3:0] exp_da;
        ifa.enable = 1'b0; ifa.duty = '0;
        ifb.enable = 1'b0; ifb.duty = '0;
        ifc.enable = 1'b0; ifc.duty = '0;

        // Reset state
        @(negedge clk);
        check("rst_a_pwm", ifa.pwm_out, 0);
        check("rst_a_pend", ifa.period_end, 0);
        check("rst_a_da", ifa.duty_active, 0);
        check("rst_c_pwm", ifc.pwm_out, 1);
        @(negedge clk);
        rst = 1'b0;

        // Duty 5 at prescale 1: 5 high, 10 low, period_end every 15th clock
        ifa.duty = 4'd5; ifa.enable = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("t1_pwm", ifa.pwm_out, 32'((k % 15) < 5));
            check("t1_pend", ifa.period_end, 32'((k % 15) == 14));
            check("t1_da", ifa.duty_active, 5);
        end

        // Duty 0 then duty 15 across several wraps
        ifa.duty = 4'd0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("t2_pwm0", ifa.pwm_out, 0);
            check("t2_pend0", ifa.period_end, 32'((k % 15) == 14));
        end
        ifa.duty = 4'd15;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("t2_pwm15", ifa.pwm_out, 1);
            check("t2_pend15", ifa.period_end, 32'((k % 15) == 14));
            check("t2_da15", ifa.duty_active, 15);
        end

        // Duty 3, changed to 9 mid-period at phase 6
        ifa.duty = 4'd3;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("t3_pwm", ifa.pwm_out, (k < 15) ? 32'(k < 3) : 32'((k - 15) < 9));
            check("t3_da", ifa.duty_active, (k < 15) ? 3 : 9);
            if (k == 6) ifa.duty = 4'd9;
        end

        // Triangle-fed duty: duty_active only moves at period boundaries
        ifa.duty = tri_val(0);
        exp_da = tri_val(0);
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            check("tri_da", ifa.duty_active, 32'(exp_da));
            check("tri_pend", ifa.period_end, 32'((k % 15) == 14));
            ifa.duty = tri_val(k + 1);
            if ((k % 15) == 14) exp_da = tri_val(k + 1);
        end

        // Enable falling on the period_end clock: strobe still seen, no reload
        ifa.duty = 4'd3;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("ef_pwm", ifa.pwm_out, 32'(k < 3));
        end
        check("ef_pend", ifa.period_end, 1);
        ifa.enable = 1'b0; ifa.duty = 4'd12;
        @(negedge clk);
        check("ef_idle_pwm", ifa.pwm_out, 0);
        check("ef_idle_pend", ifa.period_end, 0);
        check("ef_idle_da", ifa.duty_active, 3);

        // Asynchronous reset at phase 7, then restart from phase 0
        ifa.duty = 4'd10; ifa.enable = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rs_pre_pwm", ifa.pwm_out, 1);
        end
        rst = 1'b1;
        #1;
        check("rs_pwm", ifa.pwm_out, 0);
        check("rs_da", ifa.duty_active, 0);
        check("rs_pend", ifa.period_end, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("rs_run_pwm", ifa.pwm_out, 32'(k < 10));
            check("rs_run_pend", ifa.period_end, 32'(k == 14));
            check("rs_run_da", ifa.duty_active, 10);
        end
        ifa.enable = 1'b0;

        // Prescale 4, duty 2: 8 high, 52 low, period_end every 60 clocks
        ifb.duty = 4'd2; ifb.enable = 1'b1;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            check("t4_pwm", ifb.pwm_out, 32'((k % 60) < 8));
            check("t4_pend", ifb.period_end, 32'((k % 60) == 59));
        end
        check("t4_da", ifb.duty_active, 2);
        ifb.enable = 1'b0;

        // Inverted output, enable dropped mid-period, then re-enabled
        ifc.duty = 4'd6; ifc.enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6_pwm", ifc.pwm_out, 32'(!(k < 6)));
        end
        ifc.enable = 1'b0;
        @(negedge clk);
        check("t6_idle_pwm", ifc.pwm_out, 1);
        check("t6_idle_pend", ifc.period_end, 0);
        check("t6_idle_da", ifc.duty_active, 6);
        @(negedge clk);
        check("t6_idle2_pwm", ifc.pwm_out, 1);
        ifc.duty = 4'd11; ifc.enable = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("t6_re_pwm", ifc.pwm_out, 32'(!(k < 11)));
            check("t6_re_pend", ifc.period_end, 32'(k == 14));
            check("t6_re_da", ifc.duty_active, 11);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
